// File: rtl/wb_pkg.sv
// Shared types for the register write-back queue: field widths and the queued entry.
package wb_pkg;

    localparam int SEL_W  = 4;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_mem.sv
// Entry storage for writeback_queue: one write port, one combinational read port.
// With WRITEBACK_QUEUE_FWD_EN defined it also exposes every entry plus per-entry valid bits.
module wb_fifo_mem
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  push,
    input  logic [AW-1:0]         push_ptr,
    input  wb_entry_t             push_entry,
    input  logic [AW-1:0]         pop_ptr,
    output wb_entry_t             head_entry
`ifdef WRITEBACK_QUEUE_FWD_EN
    ,
    input  logic                  clear,
    input  logic                  pop,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic      [DEPTH-1:0] valid
`endif
);

    wb_entry_t mem_q [DEPTH];

    // NOTE: the array has no reset; pointers and occupancy decide which slots hold live data.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[push_ptr] <= push_entry;
        end
    end

    assign head_entry = mem_q[pop_ptr];

`ifdef WRITEBACK_QUEUE_FWD_EN
    logic [DEPTH-1:0] valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[pop_ptr] = 1'b0;
        end
        if (push) begin
            valid_d[push_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem_q[i];
        end
    end

    assign valid = valid_q;
`endif

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: buffers register write-backs and drains at most one per cycle into the
// register file. Defining WRITEBACK_QUEUE_FWD_EN builds the youngest-pending-value lookup.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_select,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   hold,
    output logic [SEL_W-1:0]       write_select,
    output logic                   write_enable,
    output logic [DATA_W-1:0]      write_data,
    output logic [$clog2(DEPTH):0] count,
    input  logic [SEL_W-1:0]       fwd_select,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    wb_entry_t     out_q, out_d;
    logic          we_q, we_d;
    logic          push, pop;
    wb_entry_t     push_entry, head_entry;

    // Ready depends only on registered occupancy and clear, never on hold or in_valid.
    assign in_ready   = (count_q != CW'(DEPTH)) & ~clear;
    assign push       = in_valid & in_ready;
    assign pop        = (count_q != '0) & ~hold;
    assign push_entry = {in_select, in_data};

`ifdef WRITEBACK_QUEUE_FWD_EN
    wb_entry_t [DEPTH-1:0] mem_entries;
    logic      [DEPTH-1:0] mem_valid;
    logic      [AW-1:0]    scan_idx;
`endif

    wb_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock      (clock),
        .push       (push),
        .push_ptr   (wr_ptr_q),
        .push_entry (push_entry),
        .pop_ptr    (rd_ptr_q),
        .head_entry (head_entry)
`ifdef WRITEBACK_QUEUE_FWD_EN
        ,
        .clear      (clear),
        .pop        (pop),
        .entries    (mem_entries),
        .valid      (mem_valid)
`endif
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path can leave it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        we_d     = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            out_d    = head_entry;
            we_d     = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            we_q     <= we_d;
        end
    end

    assign write_select = out_q.sel;
    assign write_data   = out_q.data;
    assign write_enable = we_q;
    assign count        = count_q;

`ifdef WRITEBACK_QUEUE_FWD_EN
    // The output stage is the oldest pending write; scanning oldest to youngest lets the last match win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        if (we_q && (out_q.sel == fwd_select)) begin
            fwd_hit  = 1'b1;
            fwd_data = out_q.data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + AW'(i);
            if (mem_valid[scan_idx] && (mem_entries[scan_idx].sel == fwd_select)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_entries[scan_idx].data;
            end
        end
    end
`else
    logic unused_fwd_select;
    assign unused_fwd_select = ^fwd_select;
    assign fwd_hit           = 1'b0;
    assign fwd_data          = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue against a queue-based model of the write-back rules.
// Forwarding expectations follow WRITEBACK_QUEUE_FWD_EN as defined for the build.
module tb_writeback_queue;

    localparam int DEPTH = 4;

    logic       clock      = 1'b0;
    logic       clear      = 1'b1;
    logic       in_valid   = 1'b0;
    logic [3:0] in_select  = '0;
    logic [7:0] in_data    = '0;
    logic       hold       = 1'b0;
    logic [3:0] fwd_select = '0;
    logic       in_ready;
    logic [3:0] write_select;
    logic       write_enable;
    logic [7:0] write_data;
    logic [2:0] count;
    logic       fwd_hit;
    logic [7:0] fwd_data;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: pending entries {sel,data} oldest first, plus the register-file output stage.
    logic [11:0] model_q[$];
    logic [11:0] exp_out = '0;
    logic        exp_we  = 1'b0;
    logic [11:0] exp_writes[$];
    logic [11:0] dut_writes[$];
    logic        exp_ready;
    logic        obs_ready;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_select    (in_select),
        .in_data      (in_data),
        .hold         (hold),
        .write_select (write_select),
        .write_enable (write_enable),
        .write_data   (write_data),
        .count        (count),
        .fwd_select   (fwd_select),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
    );

    always #5 clock = ~clock;

    function automatic void model_fwd(input logic [3:0] s, output logic h, output logic [7:0] d);
        h = 1'b0;
        d = 8'h00;
`ifdef WRITEBACK_QUEUE_FWD_EN
        if (exp_we && exp_out[11:8] == s) begin
            h = 1'b1;
            d = exp_out[7:0];
        end
        foreach (model_q[i]) begin
            if (model_q[i][11:8] == s) begin
                h = 1'b1;
                d = model_q[i][7:0];
            end
        end
`else
        if (s === 4'hx) h = 1'b0;
`endif
    endfunction

    // One clock cycle: drive inputs, sample in_ready before the edge, advance model and DUT.
    task automatic tick(input logic v, input logic [3:0] s, input logic [7:0] d,
                        input logic h, input logic c);
        logic acc;
        in_valid  = v;
        in_select = s;
        in_data   = d;
        hold      = h;
        clear     = c;
        #1;
        exp_ready = (model_q.size() != DEPTH) && !c;
        obs_ready = in_ready;
        @(posedge clock);
        if (c) begin
            model_q.delete();
            exp_out = '0;
            exp_we  = 1'b0;
        end else begin
            acc = v && exp_ready;
            if (model_q.size() > 0 && !h) begin
                exp_out = model_q.pop_front();
                exp_we  = 1'b1;
            end else begin
                exp_we = 1'b0;
            end
            if (acc) model_q.push_back({s, d});
        end
        #1;
        if (write_enable === 1'b1) dut_writes.push_back({write_select, write_data});
        if (exp_we) exp_writes.push_back(exp_out);
    endtask

    task automatic test_reset();
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (obs_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready_during_clear: got %b expected 0", obs_ready);
        end
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if ({write_enable, write_select, write_data, count} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: we=%b sel=%h data=%h count=%0d expected all zero",
                     write_enable, write_select, write_data, count);
        end
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (obs_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready_after: got %b expected 1", obs_ready);
        end
    endtask

    task automatic test_single_write();
        int base;
        base = dut_writes.size();
        tick(1'b1, 4'h3, 8'h5A, 1'b0, 1'b0);
        tests_run++;
        if (write_enable !== 1'b0 || count !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_edge1: we=%b count=%0d expected we=0 count=1", write_enable, count);
        end
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (write_enable !== 1'b1 || write_select !== 4'h3 || write_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL single_edge2: we=%b sel=%h data=%h expected 1/3/5a",
                     write_enable, write_select, write_data);
        end
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (write_enable !== 1'b0 || dut_writes.size() - base !== 1) begin
            tests_failed++;
            $display("FAIL single_once: we=%b writes=%0d expected we=0 writes=1",
                     write_enable, dut_writes.size() - base);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b1, 1'b0);
        end
        #1;
        tests_run++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: count=%0d ready=%b expected 4/0", count, in_ready);
        end
        tick(1'b1, 4'hF, 8'hEE, 1'b1, 1'b0);
        tests_run++;
        if (obs_ready !== 1'b0 || count !== 3'd4) begin
            tests_failed++;
            $display("FAIL fill_fifth_rejected: ready=%b count=%0d expected 0/4", obs_ready, count);
        end
        // Full with a pop in the same cycle: the offered entry must still be refused.
        tick(1'b1, 4'hF, 8'hED, 1'b0, 1'b0);
        tests_run++;
        if (obs_ready !== 1'b0 || count !== 3'd3) begin
            tests_failed++;
            $display("FAIL fill_full_pop: ready=%b count=%0d expected 0/3", obs_ready, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
            tests_run++;
            if (write_enable !== 1'b1 || {write_select, write_data} !== exp_out) begin
                tests_failed++;
                $display("FAIL fill_drain_%0d: we=%b entry=%h expected 1/%h",
                         i, write_enable, {write_select, write_data}, exp_out);
            end
        end
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (write_enable !== 1'b0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL fill_empty: we=%b count=%0d expected 0/0", write_enable, count);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 1'b0);
            tests_run++;
            if (count > 3'd1 || count !== 3'(model_q.size()) || write_enable !== exp_we ||
                {write_select, write_data} !== exp_out) begin
                tests_failed++;
                $display("FAIL stream_%0d: count=%0d we=%b entry=%h expected %0d/%b/%h", i,
                         count, write_enable, {write_select, write_data},
                         model_q.size(), exp_we, exp_out);
            end
        end
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_clear_mid_drain();
        int base;
        tick(1'b1, 4'hA, 8'hE1, 1'b1, 1'b0);
        tick(1'b1, 4'hB, 8'hE2, 1'b1, 1'b0);
        tick(1'b1, 4'hC, 8'hE3, 1'b1, 1'b0);
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (write_enable !== 1'b1 || write_data !== 8'hE1 || count !== 3'd2) begin
            tests_failed++;
            $display("FAIL clear_pre: we=%b data=%h count=%0d expected 1/e1/2",
                     write_enable, write_data, count);
        end
        tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (obs_ready !== 1'b0 || write_enable !== 1'b0 || count !== 3'd0 ||
            write_select !== 4'h0 || write_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL clear_post: ready=%b we=%b count=%0d sel=%h data=%h expected all 0",
                     obs_ready, write_enable, count, write_select, write_data);
        end
        base = dut_writes.size();
        for (int i = 0; i < 4; i++) tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        fwd_select = 4'hB;
        #1;
        tests_run++;
        if (dut_writes.size() !== base || fwd_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_discarded: writes=%0d hit=%b expected %0d/0",
                     dut_writes.size(), fwd_hit, base);
        end
    endtask

    task automatic test_forwarding();
        logic       mh;
        logic [7:0] md;
        logic       want_hit;
        logic [7:0] want_data;
`ifdef WRITEBACK_QUEUE_FWD_EN
        want_hit  = 1'b1;
        want_data = 8'h22;
`else
        want_hit  = 1'b0;
        want_data = 8'h00;
`endif
        fwd_select = 4'h7;
        tick(1'b1, 4'h7, 8'h11, 1'b1, 1'b0);
        tick(1'b1, 4'h7, 8'h22, 1'b1, 1'b0);
        tests_run++;
        if (fwd_hit !== want_hit || fwd_data !== want_data) begin
            tests_failed++;
            $display("FAIL fwd_youngest: hit=%b data=%h expected %b/%h",
                     fwd_hit, fwd_data, want_hit, want_data);
        end
        fwd_select = 4'h2;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b0 || fwd_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL fwd_miss: hit=%b data=%h expected 0/00", fwd_hit, fwd_data);
        end
        fwd_select = 4'h7;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
            model_fwd(fwd_select, mh, md);
            tests_run++;
            if (fwd_hit !== mh || fwd_data !== md) begin
                tests_failed++;
                $display("FAIL fwd_drain_%0d: hit=%b data=%h expected %b/%h",
                         i, fwd_hit, fwd_data, mh, md);
            end
        end
    endtask

    task automatic test_random();
        logic       mh;
        logic [7:0] md;
        for (int i = 0; i < 400; i++) begin
            fwd_select = 4'($urandom_range(0, 3));
            tick(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 3)), 8'($urandom),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 49) == 0));
            model_fwd(fwd_select, mh, md);
            tests_run++;
            if (obs_ready !== exp_ready || count !== 3'(model_q.size()) ||
                write_enable !== exp_we || {write_select, write_data} !== exp_out ||
                fwd_hit !== mh || fwd_data !== md) begin
                tests_failed++;
                $display("FAIL random_%0d: ready=%b count=%0d we=%b entry=%h hit=%b fwd=%h expected %b/%0d/%b/%h/%b/%h",
                         i, obs_ready, count, write_enable, {write_select, write_data},
                         fwd_hit, fwd_data, exp_ready, model_q.size(), exp_we, exp_out, mh, md);
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_write_log();
        int bad;
        bad = -1;
        for (int i = 0; i < exp_writes.size() && i < dut_writes.size(); i++) begin
            if (bad < 0 && dut_writes[i] !== exp_writes[i]) bad = i;
        end
        tests_run++;
        if (dut_writes.size() !== exp_writes.size() || bad >= 0) begin
            tests_failed++;
            $display("FAIL write_log: writes=%0d first_bad=%0d expected writes=%0d first_bad=-1",
                     dut_writes.size(), bad, exp_writes.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_streaming();
        test_clear_mid_drain();
        test_forwarding();
        test_random();
        test_write_log();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
